arb_mux: RTL

- Parametrised successor to the datapath's combinational W-bit, N-input mux.
- Adds per-channel valid/ready handshakes and a registered output stage.
- Two selection modes: fixed select (sel-driven) or round-robin arbitration among valid channels.
- Used wherever several producers share one W-bit datapath sink, e.g. writeback or memory-request merging.

---
 rtl/arb_mux_pkg.sv | 15 +
 rtl/arb_mux_rr_pick.sv | 33 +++
 rtl/arb_mux.sv | 93 +++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrated W-bit channel mux.
package arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2 for elaboration-time width derivation (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotating priority encoder: first asserted request at or after base wins.
module rr_pick #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] base,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt
);

    int   idx;
    logic found;

    // Scan base, base+1, ... wrapping mod N. base < 2^SELW < 2N, so
    // base+k stays below 3N and two conditional subtractions bring it in range.
    always_comb begin
        gnt_valid = |req;
        gnt       = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(base) + k;
            if (idx >= N) idx = idx - N;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt   = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-input, W-bit mux with per-channel valid/ready, fixed or round-robin
// selection, and a single registered output stage.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int N    = 4,
    localparam int SELW = (N > 1) ? clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [SELW-1:0]  sel,
    input  logic             mode,
    output logic [W-1:0]     out,
    output logic [SELW-1:0]  out_ch,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int              NP   = 1 << SELW;
    localparam logic [SELW:0]   NLIM = (SELW+1)'(N);

    logic            can_load;
    logic            grant_valid;
    logic [SELW-1:0] grant;
    logic            fix_valid;
    logic            rr_valid;
    logic [SELW-1:0] rr_gnt;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_nxt;
    logic [NP-1:0]   vpad;
    logic [W-1:0]    gdata;
    logic            xfer;

    // The slot is free when empty or being drained this cycle.
    assign can_load = !out_valid || out_ready;

    rr_pick #(.N(N), .SELW(SELW)) u_pick (
        .req       (in_valid),
        .base      (ptr),
        .gnt_valid (rr_valid),
        .gnt       (rr_gnt)
    );

    // Grant select; in_valid is zero-padded so an out-of-range sel never
    // indexes past the vector and simply yields no grant.
    always_comb begin
        vpad          = '0;
        vpad[N-1:0]   = in_valid;
        fix_valid     = ({1'b0, sel} < NLIM) && vpad[sel];
        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant       = rr_gnt;
        end else begin
            grant_valid = fix_valid;
            grant       = sel;
        end
    end

    // One-hot ready to the granted channel and data mux for the winner.
    always_comb begin
        in_ready = '0;
        gdata    = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !rst && can_load && grant_valid && (grant == SELW'(i));
            if (grant == SELW'(i)) gdata = in[i*W +: W];
        end
    end

    assign xfer    = |(in_valid & in_ready);
    assign ptr_nxt = (grant == SELW'(N-1)) ? '0 : grant + 1'b1;

    // Output stage and round-robin pointer; a load overrides a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (xfer) begin
            out       <= gdata;
            out_ch    <= grant;
            out_valid <= 1'b1;
            if (mode == MODE_RR) ptr <= ptr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
